logic_serial_engine: RTL and testbench
======================================

Name: logic_serial_engine

Overview:
- Bit-serial front end for the 1-bit logic cell (inputs Ai, Bi, S1, S0; output H).
- Accepts a WIDTH-bit operand pair plus a 2-bit select through a valid/ready handshake.
- Streams the operands LSB-first through an internal 1-bit logic slice, one bit per clock.
- Reassembles the result word and presents it through a second valid/ready handshake.
- It is the consumer/collector side of the cell: it drives the cell's inputs and gathers its H output, replacing the open-loop stimulus used at block level.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand word available
in_ready  output  1  engine can accept an operand word
A  input  WIDTH  operand A, sampled on the accept edge
B  input  WIDTH  operand B, sampled on the accept edge
S  input  2  function select {S1,S0}, sampled on the accept edge
out_valid  output  1  result word H is valid
out_ready  input  1  downstream accepts the result
H  output  WIDTH  result word
busy  output  1  high while in SHIFT state
bit_cnt  output  $clog2(WIDTH)+1  number of bits processed in the current operation (debug/visibility)

Behaviour:
- Reset is synchronous on the clk edge where rst=1. All of the following take effect on that edge:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, H=0, bit_cnt=0, internal shift registers=0.
  - rst mid-operation abandons the operation; no partial result is ever presented.
- Per-bit function (S1,S0):
  - 00: H=Ai&Bi
  - 01: H=Ai|Bi
  - 10: H=Ai^Bi
  - 11: H=~Ai (Bi ignored)
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&in_ready: latch A, B and S into shift registers, clear bit_cnt, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each cycle: apply the function to the LSB of each shift register, shift the bit in at the MSB of the result register, shift the operands right, increment bit_cnt.
  - When bit_cnt reaches WIDTH-1 on the current edge (last bit processed), go to DONE with the full result in H.
- DONE:
  - out_valid=1, H held stable, in_ready=0.
  - On an edge with out_valid&out_ready: out_valid drops and the engine goes to IDLE.
- Latency: acceptance on edge N gives out_valid=1 after edge N+WIDTH.
- Throughput: one word per WIDTH+2 cycles minimum (accept, WIDTH shifts, handoff). No back-to-back overlap.
- Select latching: S is latched once per operation. Changes on S, A or B after acceptance have no effect.
- Back-pressure: out_ready=0 holds the engine in DONE indefinitely, with H and out_valid stable and in_valid ignored.
- No combinational paths:
  - in_ready does not depend on in_valid.
  - out_valid does not depend on out_ready.
- Upstream rule: in_valid is allowed to stay high while in_ready=0. The word is taken only on the accept edge.
- H is visible only in DONE and holds its last value otherwise. Benches check H only while out_valid=1.

Test Plan:
- Reset then single AND op, WIDTH=8: A=0xF0, B=0xCC, S=00, out_ready=1 -> out_valid=1 exactly 8 cycles after accept, H=0xC0, then in_ready=1 one cycle later.
- All four functions back-to-back, A=0xA5, B=0x3C:
  - S=00 -> H=0x24
  - S=01 -> H=0xBD
  - S=10 -> H=0x99
  - S=11 -> H=0x5A
  - Each op takes WIDTH+2 cycles.
- Cell truth-table sweep at WIDTH=2: pairs {Ai,Bi}=10/11 with S=00 give 0/1; 10/00 with S=01 give 1/0; 00/10 with S=10 give 0/1; 10/11 with S=11 give 0/0. Pack each pair into a 2-bit operand and check H bitwise.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> H stable, in_ready=0, second word not accepted until after the handoff.
- Mid-op reset: assert rst after 3 shifts -> next edge gives out_valid=0, busy=0, in_ready=1, H=0. A fresh op then returns the correct result.
- Input perturbation: change A, B and S every cycle during SHIFT -> result equals the function of the values latched at accept.

Source files
------------

// File: rtl/logic_serial_engine_if.sv
// Handshake bundle for the bit-serial logic engine: operand word in, result word out.
interface logic_serial_engine_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       S;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] H;

  // Producer/consumer side that feeds operands and collects results.
  modport master (
    output in_valid, A, B, S, out_ready,
    input  in_ready, out_valid, H
  );

  // Engine side.
  modport slave (
    input  in_valid, A, B, S, out_ready,
    output in_ready, out_valid, H
  );
endinterface

// File: rtl/logic_serial_engine.sv
// Bit-serial front end for the 1-bit logic cell. Latches an operand pair and a function
// select, streams the operands LSB-first through the cell one bit per clock, and presents
// the reassembled result word through a valid/ready handshake.
module logic_serial_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  logic_serial_engine_if.slave   bus,
  output logic                   busy,
  output logic [$clog2(WIDTH):0] bit_cnt
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic [1:0]       sel_q, sel_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             slice_h;
  logic [WIDTH-1:0] res_next;

  // The 1-bit logic cell, fed from the LSBs of the operand shift registers.
  always_comb begin
    slice_h = 1'b0;
    unique case (sel_q)
      2'b00: slice_h = a_q[0] & b_q[0];
      2'b01: slice_h = a_q[0] | b_q[0];
      2'b10: slice_h = a_q[0] ^ b_q[0];
      2'b11: slice_h = ~a_q[0];
      default: slice_h = 1'b0;
    endcase
  end

  // Result bits enter at the MSB so that after WIDTH shifts the first (LSB) bit is at bit 0.
  assign res_next = {slice_h, res_q[WIDTH-1:1]};

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    h_d         = h_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.A;
          b_d        = bus.B;
          sel_d      = bus.S;
          res_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = StShift;
        end
      end
      StShift: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          h_d         = res_next;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = StDone;
        end
      end
      StDone: begin
        // in_valid is ignored here; the next word waits for the return to idle.
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      h_q         <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      h_q         <= h_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.H         = h_q;
  assign busy          = busy_q;
  assign bit_cnt       = cnt_q;

endmodule

// File: tb/tb_logic_serial_engine.sv
// Directed bench for logic_serial_engine: 8-bit instance for the function, latency,
// back-pressure, reset and perturbation cases; 2-bit instance for the cell truth table.
module tb_logic_serial_engine;

  localparam int W8 = 8;
  localparam int W2 = 2;

  logic clk;
  logic rst;
  logic busy8, busy2;
  logic [$clog2(W8):0] bc8;
  logic [$clog2(W2):0] bc2;

  int checks = 0;
  int errors = 0;

  logic_serial_engine_if #(.WIDTH(W8)) bus8 ();
  logic_serial_engine_if #(.WIDTH(W2)) bus2 ();

  logic_serial_engine #(.WIDTH(W8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus8),
    .busy    (busy8),
    .bit_cnt (bc8)
  );

  logic_serial_engine #(.WIDTH(W2)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus2),
    .busy    (busy2),
    .bit_cnt (bc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] s;
    logic [7:0] h;
    bit         perturb;
    int         hold;
  } vec8_t;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] s;
    logic [1:0] h;
  } vec2_t;

  vec8_t vecs8[8];
  vec2_t vecs2[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller is #1 after a rising edge with the engine idle.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                         input logic [7:0] exp_h, input bit perturb, input int hold);
    int lat;
    check("w8 in_ready idle", 32'(bus8.in_ready), 32'(1));
    bus8.out_ready = (hold == 0);
    bus8.in_valid  = 1'b1;
    bus8.A         = a;
    bus8.B         = b;
    bus8.S         = s;
    @(posedge clk); #1;
    lat = 0;
    while (!bus8.out_valid && lat < 4 * W8) begin
      if (lat == 0) begin
        check("w8 busy in shift", 32'(busy8), 32'(1));
        check("w8 in_ready in shift", 32'(bus8.in_ready), 32'(0));
      end
      if (perturb) begin
        bus8.A        = 8'($urandom);
        bus8.B        = 8'($urandom);
        bus8.S        = 2'($urandom);
        bus8.in_valid = 1'($urandom);
      end else begin
        bus8.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus8.in_valid = 1'b0;
    check("w8 latency", 32'(lat), 32'(W8));
    check("w8 H", 32'(bus8.H), 32'(exp_h));
    check("w8 bit_cnt done", 32'(bc8), 32'(W8));
    for (int i = 0; i < hold; i++) begin
      // Offer a different word while stalled; it must not be taken.
      bus8.in_valid = i[0] ? 1'b0 : 1'b1;
      bus8.A        = ~a;
      bus8.B        = 8'h00;
      bus8.S        = 2'b01;
      @(posedge clk); #1;
      check("bp H stable", 32'(bus8.H), 32'(exp_h));
      check("bp out_valid", 32'(bus8.out_valid), 32'(1));
      check("bp in_ready", 32'(bus8.in_ready), 32'(0));
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    check("w8 out_valid after handoff", 32'(bus8.out_valid), 32'(0));
    check("w8 in_ready after handoff", 32'(bus8.in_ready), 32'(1));
    check("w8 busy after handoff", 32'(busy8), 32'(0));
  endtask

  task automatic run_op2(input logic [1:0] a, input logic [1:0] b, input logic [1:0] s,
                         input logic [1:0] exp_h);
    int lat;
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    bus2.A         = a;
    bus2.B         = b;
    bus2.S         = s;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    lat = 0;
    while (!bus2.out_valid && lat < 4 * W2) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w2 latency", 32'(lat), 32'(W2));
    check("w2 H", 32'(bus2.H), 32'(exp_h));
    @(posedge clk); #1;
    check("w2 in_ready after handoff", 32'(bus2.in_ready), 32'(1));
  endtask

  initial begin
    vecs8[0] = '{a: 8'hF0, b: 8'hCC, s: 2'b00, h: 8'hC0, perturb: 1'b0, hold: 0};
    vecs8[1] = '{a: 8'hA5, b: 8'h3C, s: 2'b00, h: 8'h24, perturb: 1'b0, hold: 0};
    vecs8[2] = '{a: 8'hA5, b: 8'h3C, s: 2'b01, h: 8'hBD, perturb: 1'b0, hold: 0};
    vecs8[3] = '{a: 8'hA5, b: 8'h3C, s: 2'b10, h: 8'h99, perturb: 1'b0, hold: 0};
    vecs8[4] = '{a: 8'hA5, b: 8'h3C, s: 2'b11, h: 8'h5A, perturb: 1'b0, hold: 0};
    vecs8[5] = '{a: 8'h5A, b: 8'h0F, s: 2'b10, h: 8'h55, perturb: 1'b1, hold: 0};
    vecs8[6] = '{a: 8'h81, b: 8'hFF, s: 2'b11, h: 8'h7E, perturb: 1'b1, hold: 0};
    vecs8[7] = '{a: 8'h0F, b: 8'h30, s: 2'b01, h: 8'h3F, perturb: 1'b0, hold: 5};

    vecs2[0] = '{a: 2'b11, b: 2'b10, s: 2'b00, h: 2'b10};
    vecs2[1] = '{a: 2'b01, b: 2'b00, s: 2'b01, h: 2'b01};
    vecs2[2] = '{a: 2'b10, b: 2'b00, s: 2'b10, h: 2'b10};
    vecs2[3] = '{a: 2'b11, b: 2'b10, s: 2'b11, h: 2'b00};

    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.S = '0; bus8.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.A = '0; bus2.B = '0; bus2.S = '0; bus2.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus8.in_ready), 32'(1));
    check("reset out_valid", 32'(bus8.out_valid), 32'(0));
    check("reset busy", 32'(busy8), 32'(0));
    check("reset H", 32'(bus8.H), 32'(0));
    check("reset bit_cnt", 32'(bc8), 32'(0));
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op8(vecs8[i].a, vecs8[i].b, vecs8[i].s, vecs8[i].h, vecs8[i].perturb, vecs8[i].hold);

    for (int i = 0; i < 4; i++)
      run_op2(vecs2[i].a, vecs2[i].b, vecs2[i].s, vecs2[i].h);

    // Mid-operation reset after three shifts.
    bus8.in_valid = 1'b1;
    bus8.A = 8'hFF; bus8.B = 8'hFF; bus8.S = 2'b00;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst bit_cnt before", 32'(bc8), 32'(3));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst out_valid", 32'(bus8.out_valid), 32'(0));
    check("midrst busy", 32'(busy8), 32'(0));
    check("midrst in_ready", 32'(bus8.in_ready), 32'(1));
    check("midrst H", 32'(bus8.H), 32'(0));
    check("midrst bit_cnt", 32'(bc8), 32'(0));
    repeat (W8 + 2) @(posedge clk);
    #1;
    check("midrst no partial result", 32'(bus8.out_valid), 32'(0));
    run_op8(8'hC3, 8'h0F, 2'b10, 8'hCC, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
